multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multi-cycle main control unit for the RV32I datapath. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
//  Issues per-state datapath strobes and handles req/ready handshakes to instruction and data memory.
//  Adds LUI, AUIPC, JAL and JALR support, illegal-opcode detection and a memory-timeout fault.
//  Sits between the instruction register (Opcode source) and the datapath muxes, register file, PC and memories.
// PARAMETERS
//  OPCODE_W     7   opcode field width
//  MEM_TIMEOUT  16  max cycles waiting on imem_ready/dmem_ready before fault; 0 disables timeout
//  CNT_W        5   wait-counter width; must hold MEM_TIMEOUT
// PORTS
//  clk           in   1         clock, all state updates on rising edge
//  reset         in   1         synchronous, active-high
//  Opcode        in   OPCODE_W  instr[6:0] from instruction register
//  br_taken      in   1         ALU branch-compare result, valid in EXEC
//  imem_ready    in   1         instruction memory response valid
//  dmem_ready    in   1         data memory access complete
//  imem_req      out  1         instruction fetch request
//  IRWrite       out  1         load instruction register
//  ALUSrc        out  1         0: rs2, 1: immediate
//  ALUOp         out  2         00 add (addr/AUIPC/JAL), 01 branch compare, 10 R-type, 11 I-type
//  MemRead       out  1         data memory read request
//  MemWrite      out  1         data memory write request
//  MemtoReg      out  2         WB select: 00 ALU, 01 mem, 10 PC+4, 11 imm (LUI)
//  RegWrite      out  1         register file write enable
//  PCWrite       out  1         PC update strobe
//  PCSel         out  2         00 PC+4, 01 branch target, 10 JAL target, 11 JALR target (ALU & ~1)
//  illegal_instr out  1         sticky: unsupported opcode decoded
//  mem_fault     out  1         sticky: memory handshake timeout
// BEHAVIOUR
//  Reset: state=FETCH, wait counter=0, latched class=NONE, both sticky flags=0.
//   While reset=1, all outputs=0. imem_req rises in the first cycle after reset falls.
//  Outputs are combinational from the state register and the latched opcode class. No output depends on Opcode outside DECODE.
//  FETCH: imem_req=1 until imem_ready.
//   On imem_ready: IRWrite=1 for that cycle only; next state DECODE.
//  DECODE: latch class from Opcode: R, I, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR.
//   Unknown opcode: next state TRAP, illegal_instr<=1. Otherwise next state EXEC.
//  EXEC (one cycle): drive ALUSrc/ALUOp for the class.
//   BRANCH: PCWrite=1; PCSel=01 if br_taken else 00; next state FETCH.
//   LOAD/STORE: next state MEM.
//   All other classes: next state WB.
//  MEM: LOAD holds MemRead=1, STORE holds MemWrite=1, until dmem_ready.
//   LOAD then goes to WB.
//   STORE: PCWrite=1, PCSel=00 in the dmem_ready cycle; next state FETCH.
//  WB (one cycle): RegWrite=1 and PCWrite=1.
//   PCSel: 10 for JAL, 11 for JALR, else 00.
//   MemtoReg: 01 LOAD, 10 JAL/JALR, 11 LUI, else 00.
//   Next state FETCH.
//  Latency (cycles, zero-wait memory): R/I/LUI/AUIPC/JAL/JALR 4; branch 3; load 5; store 4. Each memory wait cycle adds 1.
//  Wait counter: cleared on entry to FETCH/MEM; increments each cycle ready=0.
//   If MEM_TIMEOUT>0 and count==MEM_TIMEOUT-1 with ready=0: next state TRAP, mem_fault<=1.
//   A ready in that same cycle wins; no fault is raised.
//  TRAP: all strobes 0; stays in TRAP until reset. Flags clear only on reset.
//  Reset mid-operation (including while req is held) aborts the access: next cycle is FETCH with all strobes deasserted during reset.
//  At most one of MemRead, MemWrite, RegWrite, IRWrite is high in any cycle.
// STRUCTURE
//  riscv_ctrl_pkg: opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR);
//   state_t enum {FETCH, DECODE, EXEC, MEM, WB, TRAP}; instr_class_t; alu_op_t; wb_sel_t; pc_sel_t.
//  Sub-module opcode_classifier: combinational Opcode -> instr_class_t plus illegal flag, reused by the pipelined core.
// TESTING
//  1 add (0110011), zero-wait memory: IRWrite at cycle 1 after reset, RegWrite+PCWrite at cycle 4, ALUOp=10, MemtoReg=00.
//  2 lw with dmem_ready delayed 3 cycles: MemRead held 4 cycles, then WB with MemtoReg=01; sw: MemWrite, no RegWrite, PCSel=00.
//  3 beq: br_taken=1 -> PCSel=01, PCWrite in EXEC, no RegWrite; br_taken=0 -> PCSel=00.
//  4 jal/jalr/lui: WB MemtoReg=10/10/11, PCSel=10/11/00; auipc: ALUOp=00, ALUSrc=1.
//  5 Opcode 7'b1111111 -> TRAP after DECODE, illegal_instr=1, strobes 0 for 20 cycles; reset clears the flag.
//  6 imem_ready held 0, MEM_TIMEOUT=16 -> mem_fault at cycle 16. Ready on cycle 16 -> no fault.
//    Reset asserted mid-MEM -> FETCH, MemRead=0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared types and opcode constants for the RV32I control units.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_NONE   = 4'd0,
    CLS_R      = 4'd1,
    CLS_I      = 4'd2,
    CLS_LOAD   = 4'd3,
    CLS_STORE  = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_LUI    = 4'd6,
    CLS_AUIPC  = 4'd7,
    CLS_JAL    = 4'd8,
    CLS_JALR   = 4'd9
  } instr_class_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_BR  = 2'b01,
    ALU_R   = 2'b10,
    ALU_I   = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JAL    = 2'b10,
    PC_JALR   = 2'b11
  } pc_sel_t;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode decoder: maps the 7-bit major opcode to an instruction class
// and flags anything the core does not implement.
module opcode_classifier
  import riscv_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 7
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output logic [3:0]          class_o,
  output logic                illegal_o
);

  // Opcode lookup; unknown encodings report CLS_NONE together with the illegal flag.
  always_comb begin
    class_o   = CLS_NONE;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_R:      class_o = CLS_R;
      OP_I:      class_o = CLS_I;
      OP_LOAD:   class_o = CLS_LOAD;
      OP_STORE:  class_o = CLS_STORE;
      OP_BRANCH: class_o = CLS_BRANCH;
      OP_LUI:    class_o = CLS_LUI;
      OP_AUIPC:  class_o = CLS_AUIPC;
      OP_JAL:    class_o = CLS_JAL;
      OP_JALR:   class_o = CLS_JALR;
      default: begin
        class_o   = CLS_NONE;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory handshakes, a wait-cycle timeout and sticky fault flags.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 7,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                br_taken,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                IRWrite,
  output logic                ALUSrc,
  output logic [1:0]          ALUOp,
  output logic                MemRead,
  output logic                MemWrite,
  output logic [1:0]          MemtoReg,
  output logic                RegWrite,
  output logic                PCWrite,
  output logic [1:0]          PCSel,
  output logic                illegal_instr,
  output logic                mem_fault
);

  localparam logic             TIMEOUT_EN   = (MEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t           state_q, state_d;
  instr_class_t     cls_q, cls_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             fault_q, fault_d;

  logic [3:0] dec_class_s;
  logic       dec_illegal_s;
  logic       timeout_s;

  logic    imem_req_s, ir_write_s, alu_src_s, mem_read_s, mem_write_s;
  logic    reg_write_s, pc_write_s;
  alu_op_t alu_op_s;
  wb_sel_t wb_sel_s;
  pc_sel_t pc_sel_s;

  opcode_classifier #(.OPCODE_W(OPCODE_W)) u_classifier (
    .opcode_i  (Opcode),
    .class_o   (dec_class_s),
    .illegal_o (dec_illegal_s)
  );

  // A ready in the last allowed cycle takes priority over the timeout in the FSM below.
  assign timeout_s = TIMEOUT_EN && (cnt_q == TIMEOUT_LAST);

  // Next-state, wait counter and per-state datapath strobes.
  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    cnt_d       = cnt_q;
    illegal_d   = illegal_q;
    fault_d     = fault_q;
    imem_req_s  = 1'b0;
    ir_write_s  = 1'b0;
    alu_src_s   = 1'b0;
    alu_op_s    = ALU_ADD;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    wb_sel_s    = WB_ALU;
    reg_write_s = 1'b0;
    pc_write_s  = 1'b0;
    pc_sel_s    = PC_PLUS4;
    case (state_q)
      FETCH: begin
        imem_req_s = 1'b1;
        if (imem_ready) begin
          ir_write_s = 1'b1;
          state_d    = DECODE;
        end else if (timeout_s) begin
          state_d = TRAP;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DECODE: begin
        cls_d = instr_class_t'(dec_class_s);
        if (dec_illegal_s) begin
          state_d   = TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (cls_q)
          CLS_R: begin
            alu_op_s = ALU_R;
            state_d  = WB;
          end
          CLS_I: begin
            alu_src_s = 1'b1;
            alu_op_s  = ALU_I;
            state_d   = WB;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src_s = 1'b1;
            state_d   = MEM;
            cnt_d     = CNT_ZERO;
          end
          CLS_BRANCH: begin
            alu_op_s   = ALU_BR;
            pc_write_s = 1'b1;
            pc_sel_s   = br_taken ? PC_BRANCH : PC_PLUS4;
            state_d    = FETCH;
            cnt_d      = CNT_ZERO;
          end
          CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR: begin
            alu_src_s = 1'b1;
            state_d   = WB;
          end
          default: state_d = TRAP;
        endcase
      end
      MEM: begin
        mem_read_s  = (cls_q == CLS_LOAD);
        mem_write_s = (cls_q == CLS_STORE);
        if (dmem_ready) begin
          if (cls_q == CLS_STORE) begin
            pc_write_s = 1'b1;
            state_d    = FETCH;
            cnt_d      = CNT_ZERO;
          end else begin
            state_d = WB;
          end
        end else if (timeout_s) begin
          state_d = TRAP;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WB: begin
        reg_write_s = 1'b1;
        pc_write_s  = 1'b1;
        case (cls_q)
          CLS_LOAD: wb_sel_s = WB_MEM;
          CLS_JAL: begin
            wb_sel_s = WB_PC4;
            pc_sel_s = PC_JAL;
          end
          CLS_JALR: begin
            wb_sel_s = WB_PC4;
            pc_sel_s = PC_JALR;
          end
          CLS_LUI: wb_sel_s = WB_IMM;
          default: wb_sel_s = WB_ALU;
        endcase
        state_d = FETCH;
        cnt_d   = CNT_ZERO;
      end
      TRAP:    state_d = TRAP;
      default: state_d = TRAP;
    endcase
  end

  // State, latched class, wait counter and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      cls_q     <= CLS_NONE;
      cnt_q     <= CNT_ZERO;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
    end
  end

  // Everything is forced low while reset is held, including the sticky flags.
  assign imem_req      = imem_req_s  & ~reset;
  assign IRWrite       = ir_write_s  & ~reset;
  assign ALUSrc        = alu_src_s   & ~reset;
  assign ALUOp         = reset ? 2'b00 : alu_op_s;
  assign MemRead       = mem_read_s  & ~reset;
  assign MemWrite      = mem_write_s & ~reset;
  assign MemtoReg      = reset ? 2'b00 : wb_sel_s;
  assign RegWrite      = reg_write_s & ~reset;
  assign PCWrite       = pc_write_s  & ~reset;
  assign PCSel         = reset ? 2'b00 : pc_sel_s;
  assign illegal_instr = illegal_q   & ~reset;
  assign mem_fault     = fault_q     & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: a per-instruction trace model builds expected strobes cycle by cycle.
module tb_multicycle_controller;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset;
  logic [6:0] Opcode;
  logic br_taken, imem_ready, dmem_ready;
  logic imem_req, IRWrite, ALUSrc, MemRead, MemWrite, RegWrite, PCWrite;
  logic illegal_instr, mem_fault;
  logic [1:0] ALUOp, MemtoReg, PCSel;
  logic [14:0] obs_v;

  typedef struct packed {
    logic [6:0] opc;
    logic       ir;
    logic       dr;
    logic       bt;
  } stim_t;

  stim_t       stim_q[$];
  logic [14:0] exp_q[$];
  logic [14:0] obs_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  bit  m_ill, m_flt, m_trap;

  multicycle_controller #(.OPCODE_W(7), .MEM_TIMEOUT(TMO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .br_taken(br_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .IRWrite(IRWrite), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .PCWrite(PCWrite), .PCSel(PCSel), .illegal_instr(illegal_instr),
    .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  assign obs_v = {imem_req, IRWrite, ALUSrc, ALUOp, MemRead, MemWrite, MemtoReg,
                  RegWrite, PCWrite, PCSel, illegal_instr, mem_fault};

  function automatic logic [6:0] r7();
    return 7'($urandom);
  endfunction

  function automatic logic r1();
    return 1'($urandom);
  endfunction

  function automatic logic [12:0] o13(input logic ireq, input logic irw, input logic asrc,
                                      input logic [1:0] aop, input logic mr, input logic mw,
                                      input logic [1:0] m2r, input logic rw, input logic pcw,
                                      input logic [1:0] pcs);
    return {ireq, irw, asrc, aop, mr, mw, m2r, rw, pcw, pcs};
  endfunction

  task automatic push(input logic [12:0] o, input logic [6:0] opc, input logic ir,
                      input logic dr, input logic bt);
    stim_t s;
    s.opc = opc; s.ir = ir; s.dr = dr; s.bt = bt;
    stim_q.push_back(s);
    exp_q.push_back({o, m_ill, m_flt});
  endtask

  task automatic add_trap(input int n);
    for (int i = 0; i < n; i++) push(13'h0000, r7(), r1(), r1(), r1());
  endtask

  // Expected behaviour of one instruction; inputs outside their relevant phase are random.
  task automatic add_instr(input logic [6:0] op, input int fw, input int mw, input logic bt);
    bit is_r, is_i, is_ld, is_st, is_br, is_lui, is_aui, is_jal, is_jalr, legal;
    logic [1:0] aop, m2r, pcs;
    is_r = (op == OP_R); is_i = (op == OP_I); is_ld = (op == OP_LD); is_st = (op == OP_ST);
    is_br = (op == OP_BR); is_lui = (op == OP_LUI); is_aui = (op == OP_AUI);
    is_jal = (op == OP_JAL); is_jalr = (op == OP_JALR);
    legal = is_r | is_i | is_ld | is_st | is_br | is_lui | is_aui | is_jal | is_jalr;
    if (m_trap) return;
    for (int i = 0; i < fw && i < TMO; i++)
      push(o13(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00), r7(), 1'b0, r1(), r1());
    if (fw >= TMO) begin m_flt = 1'b1; m_trap = 1'b1; return; end
    push(o13(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00), r7(), 1'b1, r1(), r1());
    push(13'h0000, op, r1(), r1(), r1());
    if (!legal) begin m_ill = 1'b1; m_trap = 1'b1; return; end
    aop = is_r ? 2'b10 : is_i ? 2'b11 : is_br ? 2'b01 : 2'b00;
    if (is_br) begin
      push(o13(1'b0, 1'b0, 1'b0, aop, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, bt ? 2'b01 : 2'b00),
           r7(), r1(), r1(), bt);
      return;
    end
    push(o13(1'b0, 1'b0, !is_r, aop, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00), r7(), r1(), r1(), r1());
    if (is_ld || is_st) begin
      for (int i = 0; i < mw && i < TMO; i++)
        push(o13(1'b0, 1'b0, 1'b0, 2'b00, is_ld, is_st, 2'b00, 1'b0, 1'b0, 2'b00), r7(), r1(), 1'b0, r1());
      if (mw >= TMO) begin m_flt = 1'b1; m_trap = 1'b1; return; end
      push(o13(1'b0, 1'b0, 1'b0, 2'b00, is_ld, is_st, 2'b00, 1'b0, is_st, 2'b00), r7(), r1(), 1'b1, r1());
      if (is_st) return;
    end
    m2r = is_ld ? 2'b01 : (is_jal || is_jalr) ? 2'b10 : is_lui ? 2'b11 : 2'b00;
    pcs = is_jal ? 2'b10 : is_jalr ? 2'b11 : 2'b00;
    push(o13(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, m2r, 1'b1, 1'b1, pcs), r7(), r1(), r1(), r1());
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    Opcode = r7(); imem_ready = r1(); dmem_ready = r1(); br_taken = r1();
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
    m_ill = 1'b0; m_flt = 1'b0; m_trap = 1'b0;
    stim_q.delete(); exp_q.delete(); obs_q.delete();
  endtask

  // Plays the first n stimulus entries (all when n < 0) and records outputs mid-cycle.
  task automatic run_trace(input int n);
    int lim;
    lim = (n < 0 || n > stim_q.size()) ? stim_q.size() : n;
    for (int i = 0; i < lim; i++) begin
      Opcode = stim_q[i].opc; imem_ready = stim_q[i].ir;
      dmem_ready = stim_q[i].dr; br_taken = stim_q[i].bt;
      @(negedge clk);
      obs_q.push_back(obs_v);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Opcode = r7(); imem_ready = r1(); dmem_ready = r1(); br_taken = r1();
      @(negedge clk);
      n_tests++;
      if (obs_v !== 15'h0000) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %h expected 0000", i, obs_v);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_alu();
    logic [6:0] ops[6];
    ops = '{OP_R, OP_I, OP_LUI, OP_AUI, OP_JAL, OP_JALR};
    apply_reset(2);
    add_instr(OP_R, 0, 0, 1'b0);
    foreach (ops[k]) add_instr(ops[k], 0, 0, 1'b0);
    for (int k = 0; k < 8; k++) add_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 3), 0, 1'b0);
    run_trace(-1);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL alu_ops cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_load_store();
    apply_reset(2);
    add_instr(OP_LD, 0, 3, 1'b0);
    add_instr(OP_ST, 0, 0, 1'b0);
    add_instr(OP_ST, 2, 3, 1'b0);
    for (int k = 0; k < 6; k++)
      add_instr(r1() ? OP_LD : OP_ST, $urandom_range(0, 3), $urandom_range(0, 5), 1'b0);
    run_trace(-1);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL load_store cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_branch();
    apply_reset(2);
    add_instr(OP_BR, 0, 0, 1'b1);
    add_instr(OP_BR, 0, 0, 1'b0);
    for (int k = 0; k < 6; k++) add_instr(OP_BR, $urandom_range(0, 2), 0, r1());
    run_trace(-1);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL branch cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops[9];
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_LUI, OP_AUI, OP_JAL, OP_JALR};
    apply_reset(1);
    for (int k = 0; k < 30; k++)
      add_instr(ops[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3), r1());
    run_trace(-1);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_illegal();
    apply_reset(2);
    add_instr(7'b1111111, 0, 0, 1'b0);
    add_trap(20);
    run_trace(-1);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL illegal_trap cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    apply_reset(2);
    imem_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (illegal_instr !== 1'b0 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_cleared: got ill=%b req=%b expected ill=0 req=1", illegal_instr, imem_req);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_timeout();
    apply_reset(2);
    add_instr(OP_R, 16, 0, 1'b0);
    add_trap(4);
    run_trace(-1);
    apply_reset(1);
    add_instr(OP_R, 15, 0, 1'b0);
    add_instr(OP_LD, 0, 15, 1'b0);
    add_instr(OP_LD, 0, 16, 1'b0);
    add_trap(3);
    run_trace(-1);
    // first run's observations were cleared by apply_reset; check it via cycle-16 spot checks below
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL timeout cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    apply_reset(1);
    imem_ready = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c >= 16) begin
        n_tests++;
        if (mem_fault !== (c == 17) || imem_req !== (c == 16)) begin
          n_fail++;
          $display("FAIL fetch_timeout cycle %0d: got fault=%b req=%b expected fault=%b req=%b",
                   c, mem_fault, imem_req, (c == 17), (c == 16));
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_mem();
    apply_reset(1);
    add_instr(OP_LD, 0, 5, 1'b0);
    run_trace(5);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL mid_mem_pre cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    reset = 1'b1;
    dmem_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obs_v !== 15'h0000) begin
      n_fail++;
      $display("FAIL mid_mem_reset: got %h expected 0000", obs_v);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    imem_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obs_v !== 15'h4000) begin
      n_fail++;
      $display("FAIL mid_mem_refetch: got %h expected 4000", obs_v);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; Opcode = 7'h00; imem_ready = 1'b0; dmem_ready = 1'b0; br_taken = 1'b0;
    #1;
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
